// File: rtl/fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch unit and imem.
// The fetch unit is the master; it holds the request until a one-cycle ack.
interface fetch_unit_if;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// SISC instruction-fetch stage: program counter, imem fetch FSM with timeout,
// instruction register and sticky timeout/halt status for the control FSM.
module fetch_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst_f,
    input  logic               pc_rst,
    input  logic               pc_write,
    input  logic               pc_sel,
    input  logic               br_sel,
    input  logic               ir_load,
    fetch_unit_if.master       mem,
    output logic [31:0]        ir,
    output logic [3:0]         opcode,
    output logic [3:0]         mm,
    output logic [15:0]        pc,
    output logic               fetch_busy,
    output logic               fetch_err,
    output logic               halted
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    // TIMEOUT is limited to 2..255 so the last count fits in eight bits.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);
    localparam logic [3:0] OP_HLT   = 4'hF;

    logic [0:0]  state_reg, state_next;
    logic [7:0]  cnt_reg, cnt_next;
    logic [15:0] pc_reg, pc_next;
    logic [15:0] addr_reg, addr_next;
    logic [31:0] ir_reg, ir_next;
    logic        err_reg, err_next;
    logic        halted_reg, halted_next;

    // Program counter update runs independently of the fetch FSM.
    always_comb begin
        pc_next = pc_reg;
        if (pc_rst) begin
            pc_next = 16'h0000;
        end else if (pc_write) begin
            if (!pc_sel)
                pc_next = pc_reg + 16'd1;
            else if (br_sel)
                pc_next = ir_reg[15:0];
            else
                pc_next = pc_reg + ir_reg[15:0];
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        addr_next   = addr_reg;
        ir_next     = ir_reg;
        err_next    = err_reg;
        halted_next = halted_reg;
        case (state_reg)
            ST_IDLE: begin
                if (ir_load && !halted_reg && !pc_rst) begin
                    addr_next  = pc_reg;
                    cnt_next   = 8'd0;
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Abort beats ack, and ack beats timeout on the same edge.
                if (pc_rst) begin
                    state_next = ST_IDLE;
                end else if (mem.imem_ack) begin
                    ir_next    = mem.imem_rdata;
                    state_next = ST_IDLE;
                    if (mem.imem_rdata[31:28] == OP_HLT)
                        halted_next = 1'b1;
                end else if (cnt_reg == CNT_LAST) begin
                    ir_next    = 32'h0000_0000;
                    err_next   = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt_reg + 8'd1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= 8'd0;
            pc_reg     <= 16'h0000;
            addr_reg   <= 16'h0000;
            ir_reg     <= 32'h0000_0000;
            err_reg    <= 1'b0;
            halted_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            pc_reg     <= pc_next;
            addr_reg   <= addr_next;
            ir_reg     <= ir_next;
            err_reg    <= err_next;
            halted_reg <= halted_next;
        end
    end

    assign mem.imem_req  = (state_reg == ST_WAIT);
    assign mem.imem_addr = addr_reg;
    assign fetch_busy    = (state_reg == ST_WAIT);
    assign ir            = ir_reg;
    assign opcode        = ir_reg[31:28];
    assign mm            = ir_reg[27:24];
    assign pc            = pc_reg;
    assign fetch_err     = err_reg;
    assign halted        = halted_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a transaction-level model is compared every
// cycle, and hand-computed literals pin the key scenarios.
module tb_fetch_unit;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_f = 1'b0;
    logic        pc_rst = 1'b0, pc_write = 1'b0, pc_sel = 1'b0, br_sel = 1'b0, ir_load = 1'b0;
    logic [31:0] ir;
    logic [3:0]  opcode, mm;
    logic [15:0] pc;
    logic        fetch_busy, fetch_err, halted;

    fetch_unit_if mem ();

    fetch_unit #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_f(rst_f), .pc_rst(pc_rst), .pc_write(pc_write),
        .pc_sel(pc_sel), .br_sel(br_sel), .ir_load(ir_load), .mem(mem),
        .ir(ir), .opcode(opcode), .mm(mm), .pc(pc), .fetch_busy(fetch_busy),
        .fetch_err(fetch_err), .halted(halted)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    // Model state: what the fetch stage must present after each edge.
    logic [15:0] m_pc = 0, m_addr = 0;
    logic [31:0] m_ir = 0;
    logic        m_busy = 0, m_err = 0, m_halted = 0;
    int          m_age = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 0; m_addr = 0; m_ir = 0;
        m_busy = 0; m_err = 0; m_halted = 0; m_age = 0;
    endtask

    // Applies one rising edge worth of rules to the model, using held inputs.
    task automatic model_step();
        logic [15:0] pc_n;
        pc_n = m_pc;
        if (pc_rst) pc_n = 0;
        else if (pc_write && !pc_sel) pc_n = m_pc + 16'd1;
        else if (pc_write && br_sel) pc_n = m_ir[15:0];
        else if (pc_write) pc_n = m_pc + m_ir[15:0];

        if (!m_busy) begin
            if (ir_load && !m_halted && !pc_rst) begin
                m_busy = 1; m_addr = m_pc; m_age = 0;
            end
        end else if (pc_rst) begin
            m_busy = 0;
        end else if (mem.imem_ack) begin
            m_ir = mem.imem_rdata;
            m_busy = 0;
            if (mem.imem_rdata[31:28] == 4'd15) m_halted = 1;
        end else begin
            m_age++;
            if (m_age == TO) begin
                m_ir = 0; m_err = 1; m_busy = 0;
            end
        end
        m_pc = pc_n;
    endtask

    task automatic cyc(input logic ld, input logic pw, input logic ps, input logic bs,
                       input logic pr, input logic ak, input logic [31:0] rd);
        ir_load = ld; pc_write = pw; pc_sel = ps; br_sel = bs; pc_rst = pr;
        mem.imem_ack = ak; mem.imem_rdata = rd;
        @(posedge clk);
        model_step();
        #1;
        $display("cyc ld=%0b pw=%0b ps=%0b bs=%0b pr=%0b ack=%0b rd=%h -> pc=%h ir=%h req=%0b addr=%h err=%0b hlt=%0b",
                 ld, pw, ps, bs, pr, ak, rd, pc, ir, mem.imem_req, mem.imem_addr, fetch_err, halted);
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("pc", {16'h0, pc}, {16'h0, m_pc});
            chk("ir", ir, m_ir);
            chk("opcode", {28'h0, opcode}, {28'h0, m_ir[31:28]});
            chk("mm", {28'h0, mm}, {28'h0, m_ir[27:24]});
            chk("imem_req", {31'h0, mem.imem_req}, {31'h0, m_busy});
            chk("fetch_busy", {31'h0, fetch_busy}, {31'h0, m_busy});
            chk("imem_addr", {16'h0, mem.imem_addr}, {16'h0, m_addr});
            chk("fetch_err", {31'h0, fetch_err}, {31'h0, m_err});
            chk("halted", {31'h0, halted}, {31'h0, halted});
            chk("halted_model", {31'h0, halted}, {31'h0, m_halted});
        end
    end

    initial begin
        mem.imem_ack = 1'b0;
        mem.imem_rdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pc", {16'h0, pc}, 32'h0);
        chk("rst_ir", ir, 32'h0);
        chk("rst_req", {31'h0, mem.imem_req}, 32'h0);
        rst_f = 1'b1;
        model_reset();
        cmp_en = 1'b1;

        // Fetch with PC increment, one-cycle ack.
        cyc(1, 1, 0, 0, 0, 0, 32'h0);
        chk("t1_addr", {16'h0, mem.imem_addr}, 32'h0);
        chk("t1_pc", {16'h0, pc}, 32'h1);
        chk("t1_busy", {31'h0, fetch_busy}, 32'h1);
        cyc(0, 0, 0, 0, 0, 1, 32'h1800_0003);
        chk("t1_opcode", {28'h0, opcode}, 32'h1);
        chk("t1_mm", {28'h0, mm}, 32'h8);
        chk("t1_busy_fall", {31'h0, fetch_busy}, 32'h0);

        // Absolute then relative (wrapping) branch.
        cyc(1, 0, 0, 0, 0, 0, 32'h0);
        cyc(0, 0, 0, 0, 0, 1, 32'h4000_0020);
        cyc(0, 1, 1, 1, 0, 0, 32'h0);
        chk("t2_abs", {16'h0, pc}, 32'h0020);
        cyc(1, 1, 0, 0, 0, 0, 32'h0);
        chk("t2_pc_inc", {16'h0, pc}, 32'h0021);
        cyc(0, 0, 0, 0, 0, 1, 32'h5000_FFFE);
        cyc(0, 1, 1, 0, 0, 0, 32'h0);
        chk("t2_rel", {16'h0, pc}, 32'h001F);

        // PC+1 wrap from FFFF.
        cyc(1, 0, 0, 0, 0, 0, 32'h0);
        cyc(0, 0, 0, 0, 0, 1, 32'h4000_FFFF);
        cyc(0, 1, 1, 1, 0, 0, 32'h0);
        chk("t3_ffff", {16'h0, pc}, 32'hFFFF);
        cyc(0, 1, 0, 0, 0, 0, 32'h0);
        chk("t3_wrap", {16'h0, pc}, 32'h0);

        // Timeout: request held four cycles, then NOOP and sticky error.
        cyc(1, 0, 0, 0, 0, 0, 32'h0);
        for (int i = 0; i < TO - 1; i++) begin
            cyc(0, 0, 0, 0, 0, 0, 32'h0);
            chk("t4_req_held", {31'h0, mem.imem_req}, 32'h1);
        end
        cyc(0, 0, 0, 0, 0, 0, 32'h0);
        chk("t4_ir_noop", ir, 32'h0);
        chk("t4_err", {31'h0, fetch_err}, 32'h1);
        chk("t4_req_drop", {31'h0, mem.imem_req}, 32'h0);
        cyc(1, 0, 0, 0, 0, 0, 32'h0);
        cyc(0, 0, 0, 0, 0, 1, 32'h2100_0005);
        chk("t4_refetch", ir, 32'h2100_0005);
        chk("t4_err_sticky", {31'h0, fetch_err}, 32'h1);

        // pc_rst aborts a slow fetch; the late ack is ignored.
        cyc(1, 1, 0, 0, 0, 0, 32'h0);
        cyc(0, 0, 0, 0, 0, 0, 32'h0);
        cyc(0, 0, 0, 0, 0, 0, 32'h0);
        cyc(0, 0, 0, 0, 1, 0, 32'h0);
        chk("t5_abort_req", {31'h0, mem.imem_req}, 32'h0);
        chk("t5_abort_pc", {16'h0, pc}, 32'h0);
        cyc(0, 0, 0, 0, 0, 0, 32'h0);
        cyc(0, 0, 0, 0, 0, 0, 32'h0);
        cyc(0, 0, 0, 0, 0, 1, 32'h3300_0000);
        chk("t5_late_ack", ir, 32'h2100_0005);

        // Second ir_load mid-fetch is dropped; address stays stable.
        cyc(0, 1, 0, 0, 0, 0, 32'h0);
        cyc(1, 0, 0, 0, 0, 0, 32'h0);
        cyc(1, 1, 0, 0, 0, 0, 32'h0);
        chk("t5_addr_stable", {16'h0, mem.imem_addr}, 32'h1);
        chk("t5_pc_moved", {16'h0, pc}, 32'h2);
        cyc(0, 0, 0, 0, 0, 1, 32'h6000_0007);
        cyc(0, 0, 0, 0, 0, 0, 32'h0);
        chk("t5_no_queue", {31'h0, mem.imem_req}, 32'h0);

        // HLT sets halted and blocks further fetches.
        cyc(1, 0, 0, 0, 0, 0, 32'h0);
        cyc(0, 0, 0, 0, 0, 1, 32'hF000_0000);
        chk("t6_halted", {31'h0, halted}, 32'h1);
        chk("t6_opcode", {28'h0, opcode}, 32'hF);
        cyc(1, 0, 0, 0, 0, 0, 32'h0);
        chk("t6_no_fetch", {31'h0, mem.imem_req}, 32'h0);

        // Asynchronous reset pulse between edges.
        #1 rst_f = 1'b0;
        #1;
        chk("t6_arst_pc", {16'h0, pc}, 32'h0);
        chk("t6_arst_ir", ir, 32'h0);
        chk("t6_arst_err", {31'h0, fetch_err}, 32'h0);
        chk("t6_arst_halt", {31'h0, halted}, 32'h0);
        model_reset();
        rst_f = 1'b1;
        $display("async reset pulse applied");

        // Ack on the timeout edge: ack wins, no error.
        cyc(1, 0, 0, 0, 0, 0, 32'h0);
        chk("t7_fetch_again", {31'h0, mem.imem_req}, 32'h1);
        for (int i = 0; i < TO - 1; i++) cyc(0, 0, 0, 0, 0, 0, 32'h0);
        cyc(0, 0, 0, 0, 0, 1, 32'h7000_0011);
        chk("t7_ack_wins_ir", ir, 32'h7000_0011);
        chk("t7_ack_wins_err", {31'h0, fetch_err}, 32'h0);

        cyc(0, 0, 0, 0, 0, 0, 32'h0);
        @(posedge clk);
        cmp_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
